// File: rtl/instruction_decode.sv
// instruction_decode: RV32I decode stage with register file, branch resolution and retired-instruction counter.
module instruction_decode #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] instruction,
    input  logic            wb_enable,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic [2:0]      mem_funct3,
    output logic            branch_enable,
    output logic [XLEN-1:0] branch_offset,
    output logic            illegal_instr,
    output logic [XLEN-1:0] instret
);
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011, OPC_LUI = 7'b0110111,
                           OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

    logic [XLEN-1:0] regs_q [1:31];
    logic [XLEN-1:0] instret_q, instret_d;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]      alu_base;
    logic            dec_wr, dec_mrd, dec_mwr, is_branch, is_jal, take;
    logic            eq, lt, ltu;
    logic signed [XLEN-1:0] imm_signed, imm_shifted;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign rd     = instruction[11:7];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'd0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};

    // x0 is not stored; reads of it are forced to zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) regs_q[i] <= '0;
        end else if (wb_enable && wb_rd != 5'd0) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    assign rs1_data = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rs2_data = (rs2 == 5'd0) ? '0 : regs_q[rs2];

    assign eq  = rs1_data == rs2_data;
    assign lt  = $signed(rs1_data) < $signed(rs2_data);
    assign ltu = rs1_data < rs2_data;
    assign take = funct3[2] ? ((funct3[1] ? ltu : lt) ^ funct3[0]) : (eq ^ funct3[0]);

    always_comb begin
        alu_base = ALU_ADD;
        case (funct3)
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            3'b111:  alu_base = ALU_AND;
            default: alu_base = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_op        = ALU_ADD;
        alu_src_imm   = 1'b0;
        imm           = '0;
        dec_wr        = 1'b0;
        dec_mrd       = 1'b0;
        dec_mwr       = 1'b0;
        mem_funct3    = 3'd0;
        is_branch     = 1'b0;
        is_jal        = 1'b0;
        illegal_instr = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_wr        = 1'b1;
                alu_op        = alu_base + {3'd0, funct7[5]};
                illegal_instr = !(funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OPIMM: begin
                dec_wr        = 1'b1;
                alu_src_imm   = 1'b1;
                imm           = imm_i;
                alu_op        = (funct3 == 3'b101 && instruction[30]) ? ALU_SRA : alu_base;
                illegal_instr = (funct3 == 3'b001 && funct7 != 7'h00) ||
                                (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20);
            end
            OPC_LOAD: begin
                dec_wr        = 1'b1;
                dec_mrd       = 1'b1;
                alu_src_imm   = 1'b1;
                imm           = imm_i;
                mem_funct3    = funct3;
                illegal_instr = funct3 == 3'b011 || funct3[2:1] == 2'b11;
            end
            OPC_STORE: begin
                dec_mwr       = 1'b1;
                alu_src_imm   = 1'b1;
                imm           = imm_s;
                mem_funct3    = funct3;
                illegal_instr = funct3 > 3'b010;
            end
            OPC_BRANCH: begin
                is_branch     = 1'b1;
                alu_op        = ALU_SUB;
                imm           = imm_b;
                illegal_instr = funct3[2:1] == 2'b01;
            end
            OPC_LUI: begin
                dec_wr      = 1'b1;
                alu_src_imm = 1'b1;
                alu_op      = ALU_PASS_B;
                imm         = imm_u;
            end
            OPC_AUIPC: begin
                dec_wr      = 1'b1;
                alu_src_imm = 1'b1;
                imm         = imm_u;
            end
            OPC_JAL: begin
                dec_wr = 1'b1;
                is_jal = 1'b1;
                imm    = imm_j;
            end
            default: illegal_instr = 1'b1;
        endcase
    end

    // offset is kept signed so the shift sign-extends into instruction-word units
    assign imm_signed    = imm;
    assign imm_shifted   = imm_signed >>> 2;
    assign branch_offset = ((is_branch || is_jal) && !illegal_instr) ? imm_shifted : '0;

    assign reg_write     = reset && !illegal_instr && dec_wr;
    assign mem_read      = reset && !illegal_instr && dec_mrd;
    assign mem_write     = reset && !illegal_instr && dec_mwr;
    assign branch_enable = reset && !illegal_instr && (is_jal || (is_branch && take));

    assign instret_d = illegal_instr ? instret_q : instret_q + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) instret_q <= '0;
        else        instret_q <= instret_d;
    end

    assign instret = instret_q;
endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Stage directly downstream of instruction_fetch in the RV32I single-cycle core.
- Consumes the fetched instruction word and decodes it into control signals and a sign-extended immediate.
- Holds the 32-entry integer register file and reads rs1/rs2.
- Resolves conditional branches and JAL, and drives branch_enable/branch_offset back into instruction_fetch.
- Keeps a retired-instruction counter.

Parameters:
XLEN, 32, datapath and register width; only 32 supported.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
instruction  input  XLEN  instruction word from instruction_fetch.
wb_enable  input  1  register write strobe from writeback.
wb_rd  input  5  writeback destination register index.
wb_data  input  XLEN  writeback data.
rs1_data  output  XLEN  register file read of instruction[19:15].
rs2_data  output  XLEN  register file read of instruction[24:20].
imm  output  XLEN  sign-extended immediate, I/S/B/U/J format chosen by opcode.
rd  output  5  instruction[11:7].
alu_op  output  4  0=ADD 1=SUB 2=SLL 3=SLT 4=SLTU 5=XOR 6=SRL 7=SRA 8=OR 9=AND 10=PASS_B.
alu_src_imm  output  1  ALU operand B is imm rather than rs2_data.
reg_write  output  1  instruction writes rd.
mem_read  output  1  load.
mem_write  output  1  store.
mem_funct3  output  3  instruction[14:12] for loads/stores, else 0.
branch_enable  output  1  to instruction_fetch: take branch_offset this cycle.
branch_offset  output  XLEN  to instruction_fetch: offset in instruction (word) units.
illegal_instr  output  1  unsupported or illegal encoding.
instret  output  XLEN  retired-instruction counter.

Behaviour:
Register file
- 31 x XLEN flops for x1..x31. x0 reads 0 always.
- Write on rising clock when wb_enable=1 and wb_rd!=0. A write to x0 is discarded.
- Reads are combinational from current state; no write-to-read bypass. A read of the register being written returns the old value until the edge.
- reset low: all registers go to 0 asynchronously. While reset is low, writes are ignored.

Decode
- Fully combinational from instruction.
- Supported opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL.
- LUI: alu_op=PASS_B, alu_src_imm=1, reg_write=1.
- OP: funct7[5] selects SUB/SRA.
- OP-IMM:
  - SRAI is selected by instruction[30].
  - SLLI/SRLI/SRAI with instruction[31:25] not in {0000000, 0100000 for SRAI} -> illegal.
- JALR, SYSTEM, FENCE, any other opcode, or bits[1:0]!=11 -> illegal_instr=1. When illegal, all of these are forced 0: reg_write, mem_read, mem_write, branch_enable.
- Instruction 0x00000000 is illegal.

Branch resolution
- BEQ/BNE/BLT/BGE/BLTU/BGEU compare rs1_data vs rs2_data, signed or unsigned per funct3.
- funct3 010/011 is illegal.
- JAL: always taken, reg_write=1. The link value is outside this block's scope.
- branch_offset = B- or J-immediate arithmetically shifted right by 2. Low bits of the byte offset are dropped.
- branch_offset = 0 when not a branch/JAL.
- branch_enable = 1 only for a taken branch or JAL.

Reset overrides (while reset low)
- branch_enable=0, reg_write=0, mem_read=0, mem_write=0.
- Other decode outputs still follow instruction.

instret
- Reset value 0 (asynchronous).
- Increments by 1 on each rising edge with reset high and illegal_instr=0.
- Wraps 0xFFFFFFFF -> 0.
- An illegal instruction holds the count.

Reset mid-operation
- Register file and instret clear immediately.
- Outputs take their reset values without waiting for a clock edge.

Test Plan:
1. Reset low, then high; read any register -> rs1_data=rs2_data=0, instret=0, branch_enable=0.
2. instruction=0x00500093 (addi x1,x0,5) -> imm=5, alu_op=0, alu_src_imm=1, reg_write=1, rd=1. Then wb_enable=1, wb_rd=1, wb_data=5, clock edge; instruction=0x00008133 -> rs1_data=5.
3. wb_enable=1, wb_rd=0, wb_data=0xDEADBEEF, clock edge -> x0 reads 0. Same-cycle read of a register being written returns the old value before the edge.
4. instruction=0x00000663 (beq x0,x0,+12) -> branch_enable=1, branch_offset=3. instruction=0xFE000CE3 (beq x0,x0,-8) -> branch_offset=0xFFFFFFFE. bne x0,x0 (0xFE001CE3) -> branch_enable=0.
5. instruction=0x12345137 (lui x2) -> imm=0x12345000, alu_op=10. instruction=0x00000067 (jalr) -> illegal_instr=1, reg_write=0, instret unchanged over 3 edges.
6. Load x1 with 0x80000000 and x2 with 1; blt x1,x2 taken, bltu x1,x2 not taken. Assert reset mid-test -> registers read 0 and instret=0 immediately, branch_enable=0.
